// File: rtl/prim_recursion_ctrl.sv
// rtl/prim_recursion_ctrl.sv - primitive-recursion sequencer driving external base unit g and step unit h
module prim_recursion_ctrl #(
  parameter int BW    = 16,
  parameter int NARGS = 2,
  parameter int TMO   = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ST,
  input  logic [NARGS*BW-1:0]   ARGS,
  input  logic [BW-1:0]         N,
  output logic                  RD,
  output logic [BW-1:0]         RES,
  output logic                  ERR,
  output logic                  G_ST,
  input  logic                  G_RD,
  input  logic [BW-1:0]         G_RES,
  output logic                  H_ST,
  input  logic                  H_RD,
  input  logic [BW-1:0]         H_RES,
  output logic [NARGS*BW-1:0]   X,
  output logic [BW-1:0]         H_K,
  output logic [BW-1:0]         H_ACC
);

  localparam int CW = $clog2(TMO + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_G_START = 3'd1;
  localparam logic [2:0] S_G_WAIT  = 3'd2;
  localparam logic [2:0] S_H_START = 3'd3;
  localparam logic [2:0] S_H_WAIT  = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [NARGS*BW-1:0] x_q, x_d;
  logic [BW-1:0]       n_q, n_d;
  logic [BW-1:0]       k_q, k_d;
  logic [BW-1:0]       acc_q, acc_d;
  logic [BW-1:0]       res_q, res_d;
  logic                err_q, err_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                st_prev_q, st_prev_d;
  logic                g_rd_prev_q, g_rd_prev_d;
  logic                h_rd_prev_q, h_rd_prev_d;

  logic                st_rise;
  logic                g_done;
  logic                h_done;
  logic                tmo_hit;
  logic [BW-1:0]       k_inc;

  // Edge detectors and small helpers shared by the next-state logic
  always_comb begin
    st_rise = ST & ~st_prev_q;
    g_done  = G_RD & ~g_rd_prev_q;
    h_done  = H_RD & ~h_rd_prev_q;
    tmo_hit = (cnt_q == TMO_LAST);
    k_inc   = k_q + BW'(1);
  end

  // Next-state logic: sequence g once, then h N times; done wins over timeout
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    n_d         = n_q;
    k_d         = k_q;
    acc_d       = acc_q;
    res_d       = res_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    st_prev_d   = ST;
    g_rd_prev_d = G_RD;
    h_rd_prev_d = H_RD;

    case (state_q)
      S_IDLE: begin
        if (st_rise) begin
          x_d     = ARGS;
          n_d     = N;
          err_d   = 1'b0;
          state_d = S_G_START;
        end
      end
      S_G_START: begin
        cnt_d   = '0;
        state_d = S_G_WAIT;
      end
      S_G_WAIT: begin
        if (g_done) begin
          if (n_q == '0) begin
            res_d   = G_RES;
            state_d = S_IDLE;
          end else begin
            acc_d   = G_RES;
            k_d     = '0;
            state_d = S_H_START;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          res_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_H_START: begin
        cnt_d   = '0;
        state_d = S_H_WAIT;
      end
      S_H_WAIT: begin
        if (h_done) begin
          if (k_inc == n_q) begin
            res_d   = H_RES;
            state_d = S_IDLE;
          end else begin
            acc_d   = H_RES;
            k_d     = k_inc;
            state_d = S_H_START;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          res_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any run and clears all edge history
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      n_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      st_prev_q   <= 1'b0;
      g_rd_prev_q <= 1'b0;
      h_rd_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      n_q         <= n_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      st_prev_q   <= st_prev_d;
      g_rd_prev_q <= g_rd_prev_d;
      h_rd_prev_q <= h_rd_prev_d;
    end
  end

  // Outputs decoded from state and registered operands
  always_comb begin
    RD    = (state_q == S_IDLE);
    G_ST  = (state_q == S_G_START);
    H_ST  = (state_q == S_H_START);
    RES   = res_q;
    ERR   = err_q;
    X     = x_q;
    H_K   = k_q;
    H_ACC = acc_q;
  end

endmodule

// File: tb/tb_prim_recursion_ctrl.sv
// tb/tb_prim_recursion_ctrl.sv - scoreboard bench for prim_recursion_ctrl with g(x)=x0, h(x,k,a)=a+x1
module tb_prim_recursion_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ST;
  logic [31:0] ARGS;
  logic [15:0] N;
  logic        RD;
  logic [15:0] RES;
  logic        ERR;
  logic        G_ST;
  logic        G_RD;
  logic [15:0] G_RES;
  logic        H_ST;
  logic        H_RD;
  logic [15:0] H_RES;
  logic [31:0] X;
  logic [15:0] H_K;
  logic [15:0] H_ACC;

  typedef struct {
    logic [15:0] x0;
    logic [15:0] x1;
    logic [15:0] res;
    logic        err;
    int          n_h;
    int          lat;
    int          tmo;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   g_lat       = 3;
  int   h_lat       = 3;
  bit   h_hang      = 1'b0;
  bit   mon_en      = 1'b0;

  prim_recursion_ctrl #(.BW(16), .NARGS(2), .TMO(8)) dut (
    .CLK(CLK), .RST(RST), .ST(ST), .ARGS(ARGS), .N(N),
    .RD(RD), .RES(RES), .ERR(ERR),
    .G_ST(G_ST), .G_RD(G_RD), .G_RES(G_RES),
    .H_ST(H_ST), .H_RD(H_RD), .H_RES(H_RES),
    .X(X), .H_K(H_K), .H_ACC(H_ACC)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Base unit g: RD drops after the start, returns x0 g_lat cycles later
  logic [15:0] gv;
  initial begin
    G_RD  = 1'b1;
    G_RES = 16'h0;
    forever begin
      @(negedge CLK);
      if (G_ST === 1'b1) begin
        gv = X[15:0];
        @(posedge CLK);
        #1 G_RD = 1'b0; G_RES = 16'hDEAD;
        repeat (g_lat) @(posedge CLK);
        #1 G_RD = 1'b1; G_RES = gv;
      end
    end
  end

  // Step unit h: returns acc + x1 after h_lat cycles, or never when hanging
  logic [15:0] hv;
  bit          hang_now;
  initial begin
    H_RD  = 1'b1;
    H_RES = 16'h0;
    forever begin
      @(negedge CLK);
      if (H_ST === 1'b1) begin
        hv       = H_ACC + X[31:16];
        hang_now = h_hang;
        @(posedge CLK);
        #1 H_RD = 1'b0; H_RES = 16'hBEEF;
        if (!hang_now) begin
          repeat (h_lat) @(posedge CLK);
          #1 H_RD = 1'b1; H_RES = hv;
        end
      end
    end
  end

  // Monitor: observes pulses during a run and checks each completion against the scoreboard
  initial begin
    exp_t        e;
    int          g_cnt, h_cnt, low_cnt, wait_cnt;
    logic        rd_prev;
    logic [15:0] exp_acc;
    wait (mon_en);
    rd_prev  = 1'b1;
    g_cnt    = 0;
    h_cnt    = 0;
    low_cnt  = 0;
    wait_cnt = 0;
    forever begin
      @(negedge CLK);
      if (G_ST) begin
        g_cnt++;
        wait_cnt = 0;
        if (sb.size() > 0) chk("g_operands", X, {sb[0].x1, sb[0].x0});
      end
      if (H_ST) begin
        if (sb.size() > 0) begin
          exp_acc = 16'(32'(sb[0].x0) + 32'(h_cnt) * 32'(sb[0].x1));
          chk("h_k", {16'h0, H_K}, 32'(h_cnt));
          chk("h_acc", {16'h0, H_ACC}, {16'h0, exp_acc});
        end
        h_cnt++;
        wait_cnt = 0;
      end
      if (!RD) begin
        low_cnt++;
        if (!G_ST && !H_ST) wait_cnt++;
      end
      if (RD && !rd_prev) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: RD rose with RES=0x%0h, expected no completion", RES);
        end else begin
          e = sb.pop_front();
          chk("res", {16'h0, RES}, {16'h0, e.res});
          chk("err", {31'h0, ERR}, {31'h0, e.err});
          chk("g_pulses", 32'(g_cnt), 32'd1);
          if (e.n_h >= 0) chk("h_pulses", 32'(h_cnt), 32'(e.n_h));
          if (e.lat >= 0) chk("latency", 32'(low_cnt), 32'(e.lat));
          if (e.tmo >= 0) chk("timeout_wait", 32'(wait_cnt), 32'(e.tmo));
        end
        g_cnt    = 0;
        h_cnt    = 0;
        low_cnt  = 0;
        wait_cnt = 0;
      end
      rd_prev = RD;
    end
  end

  task automatic push_exp(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] res,
                          input logic err, input int n_h, input int lat, input int tmo);
    exp_t e;
    e.x0  = x0;
    e.x1  = x1;
    e.res = res;
    e.err = err;
    e.n_h = n_h;
    e.lat = lat;
    e.tmo = tmo;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge CLK);
      if (RD === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle: RD=%0b after 200 cycles, expected 1", RD);
    end
  endtask

  task automatic after_start_and_finish(input logic [15:0] res, input logic err);
    @(posedge CLK);
    #1 ST = 1'b0; ARGS = $urandom; N = 16'($urandom);
    @(negedge CLK);
    chk("start_rd", {31'h0, RD}, 32'd0);
    chk("start_err", {31'h0, ERR}, 32'd0);
    wait_idle();
    repeat (2) @(negedge CLK);
    chk("hold_res", {16'h0, RES}, {16'h0, res});
    chk("hold_err", {31'h0, ERR}, {31'h0, err});
  endtask

  task automatic run(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] n,
                     input logic [15:0] res, input logic err, input int n_h, input int lat, input int tmo);
    push_exp(x0, x1, res, err, n_h, lat, tmo);
    @(posedge CLK);
    #1 ARGS = {x1, x0}; N = n; ST = 1'b1;
    after_start_and_finish(res, err);
  endtask

  task automatic check_reset_state();
    chk("rst_rd", {31'h0, RD}, 32'd1);
    chk("rst_res", {16'h0, RES}, 32'd0);
    chk("rst_err", {31'h0, ERR}, 32'd0);
    chk("rst_g_st", {31'h0, G_ST}, 32'd0);
    chk("rst_h_st", {31'h0, H_ST}, 32'd0);
    chk("rst_x", X, 32'd0);
    chk("rst_h_k", {16'h0, H_K}, 32'd0);
    chk("rst_h_acc", {16'h0, H_ACC}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rx0, rx1, rn, rres;
    int          hs;

    RST  = 1'b1;
    ST   = 1'b0;
    ARGS = 32'h0;
    N    = 16'h0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_state();
    @(posedge CLK);
    #1 RST = 1'b0;
    mon_en = 1'b1;

    // Directed runs with 3-cycle sub-units
    g_lat = 3; h_lat = 3;
    run(16'd5, 16'd3, 16'd4, 16'd17, 1'b0, 4, -1, -1);
    run(16'd5, 16'd3, 16'd0, 16'd5, 1'b0, 0, 5, -1);
    run(16'hFFFF, 16'd2, 16'd1, 16'h0001, 1'b0, 1, -1, -1);

    // Hung step unit: timeout after 8 wait cycles, then a clean run clears ERR
    h_hang = 1'b1;
    run(16'd5, 16'd3, 16'd3, 16'd0, 1'b1, 1, -1, 8);
    h_hang = 1'b0;
    run(16'd2, 16'd4, 16'd2, 16'd10, 1'b0, 2, -1, -1);

    // Extra ST edge mid-run, then reset in H_WAIT with ST held high across release
    push_exp(16'd7, 16'd9, 16'd0, 1'b0, -1, -1, -1);
    @(posedge CLK);
    #1 ARGS = {16'd9, 16'd7}; N = 16'd5; ST = 1'b1;
    @(posedge CLK);
    #1 ST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 ST = 1'b1;
    @(posedge CLK);
    #1 ST = 1'b0;
    hs = 0;
    for (int i = 0; i < 100 && hs < 2; i++) begin
      @(negedge CLK);
      if (H_ST) hs++;
    end
    chk("second_h_st_seen", 32'(hs), 32'd2);
    @(posedge CLK);
    push_exp(16'd1, 16'd1, 16'd3, 1'b0, 2, -1, -1);
    #1 ARGS = {16'd1, 16'd1}; N = 16'd2; ST = 1'b1; RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check_reset_state();
    @(posedge CLK);
    #1 RST = 1'b0;
    after_start_and_finish(16'd3, 1'b0);

    // Randomized runs against x0 + N*x1 mod 2^16
    for (int t = 0; t < 25; t++) begin
      rx0   = 16'($urandom);
      rx1   = 16'($urandom);
      rn    = 16'($urandom_range(0, 6));
      g_lat = $urandom_range(1, 5);
      h_lat = $urandom_range(1, 5);
      rres  = 16'(32'(rx0) + 32'(rn) * 32'(rx1));
      run(rx0, rx1, rn, rres, 1'b0, int'(rn), -1, -1);
    end

    repeat (10) @(negedge CLK);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
